// File: rtl/sangchay_ctrl.sv
// sangchay_ctrl -- step sequencer for the 8-LED running light.
//
// A prescaler divides clk down to the pattern step rate (DIV_BASE >> speed).
// Each step request advances the LED pattern of the active mode. The request
// comes from the prescaler while running, or from the step pulse while paused.
//
// Ports:
//   clk        system clock, rising edge
//   rs         asynchronous active-low reset
//   run        1 = free-running advance, 0 = paused (prescaler holds)
//   step       one-cycle pulse, advances one step while paused
//   speed      step period = DIV_BASE >> speed
//   mode_sel   pattern to load: 0 rot-left, 1 rot-right, 2 ping-pong, 3 fill
//   mode_load  one-cycle pulse, applies mode_sel and restarts the pattern
//   led        current pattern (registered)
//   mode       active mode (registered)
//   tick       high in the first cycle a new led value is shown
module sangchay_ctrl #(
    parameter int DIV_BASE = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       run,
    input  logic       step,
    input  logic [1:0] speed,
    input  logic [1:0] mode_sel,
    input  logic       mode_load,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_ROTL = 2'd0;
    localparam logic [1:0] MODE_ROTR = 2'd1;
    localparam logic [1:0] MODE_PING = 2'd2;

    localparam logic [CNT_W-1:0] DIV_W = CNT_W'(DIV_BASE);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] thr;
    logic             adv;
    logic             adv_req;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [7:0]       led_nxt;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Legal fill values are 2^k-1 (00, 01, 03, ... FF).
    function automatic logic is_fill(input logic [7:0] v);
        return (v & (v + 8'd1)) == 8'd0;
    endfunction

    always_comb begin
        period = DIV_W >> speed;
        thr    = period - CNT_W'(1);
        // >= rather than == so that raising speed mid-count wraps at once
        // instead of running the counter up to overflow.
        adv     = run && (cnt >= thr);
        adv_req = (run && adv) || (!run && step);

        cnt_nxt = cnt;
        if (mode_load) begin
            cnt_nxt = '0;
        end else if (run) begin
            cnt_nxt = adv ? '0 : cnt + CNT_W'(1);
        end
    end

    // Next pattern value for the active mode; illegal values restart at 01.
    always_comb begin
        led_nxt = 8'h01;
        dir_nxt = dir;
        case (mode)
            MODE_ROTL: begin
                if (is_onehot(led)) led_nxt = {led[6:0], led[7]};
                else                dir_nxt = DIR_LEFT;
            end
            MODE_ROTR: begin
                if (is_onehot(led)) led_nxt = {led[0], led[7:1]};
                else                dir_nxt = DIR_LEFT;
            end
            MODE_PING: begin
                if (!is_onehot(led)) begin
                    dir_nxt = DIR_LEFT;
                end else if (dir == DIR_LEFT) begin
                    // Bounce off the end so the end LED is not shown twice.
                    if (led[7]) begin
                        led_nxt = 8'h40;
                        dir_nxt = DIR_RIGHT;
                    end else begin
                        led_nxt = led << 1;
                    end
                end else begin
                    if (led[0]) begin
                        led_nxt = 8'h02;
                        dir_nxt = DIR_LEFT;
                    end else begin
                        led_nxt = led >> 1;
                    end
                end
            end
            default: begin
                if (is_fill(led)) led_nxt = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            cnt  <= '0;
            led  <= 8'h01;
            mode <= MODE_ROTL;
            dir  <= DIR_LEFT;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= 1'b0;
            // A load wins over a same-cycle advance; that advance is dropped.
            if (mode_load) begin
                mode <= mode_sel;
                led  <= 8'h01;
                dir  <= DIR_LEFT;
            end else if (adv_req) begin
                led  <= led_nxt;
                dir  <= dir_nxt;
                tick <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sangchay_ctrl.sv
module tb_sangchay_ctrl;

    logic       clk;
    logic       rs;
    logic       run;
    logic       step;
    logic [1:0] speed;
    logic [1:0] mode_sel;
    logic       mode_load;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    int checks = 0;
    int errors = 0;

    sangchay_ctrl #(.DIV_BASE(8), .CNT_W(24)) dut (
        .clk       (clk),
        .rs        (rs),
        .run       (run),
        .step      (step),
        .speed     (speed),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .led       (led),
        .mode      (mode),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       step;
        logic [1:0] speed;
        logic [1:0] sel;
        logic       load;
        logic [7:0] exp_led;
        logic [1:0] exp_mode;
        logic       exp_tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [1:0] sp,
                       input logic [1:0] sl, input logic ld,
                       input logic [7:0] el, input logic [1:0] em, input logic et);
        vec_t v;
        v.run = r; v.step = s; v.speed = sp; v.sel = sl; v.load = ld;
        v.exp_led = el; v.exp_mode = em; v.exp_tick = et;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    logic [7:0] rotl_seq [8];
    logic [7:0] ping_seq [14];
    logic [7:0] fill_seq [10];
    logic [7:0] rotr_seq [8];

    initial begin
        rotl_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        rotr_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        ping_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        fill_seq = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                     8'h00, 8'h01, 8'h03};

        // Period-1 vectors (speed=3): every running cycle is an advance.
        add(1, 0, 3, 1, 1, 8'h01, 1, 0);
        foreach (rotr_seq[i]) add(1, 0, 3, 1, 0, rotr_seq[i], 1, 1);
        add(1, 0, 3, 2, 1, 8'h01, 2, 0);
        foreach (ping_seq[i]) add(1, 0, 3, 2, 0, ping_seq[i], 2, 1);
        add(1, 0, 3, 2, 0, 8'h02, 2, 1);
        add(1, 0, 3, 3, 1, 8'h01, 3, 0);
        foreach (fill_seq[i]) add(1, 0, 3, 3, 0, fill_seq[i], 3, 1);
        add(1, 0, 3, 3, 1, 8'h01, 3, 0);   // reload same mode restarts
        add(1, 0, 3, 3, 0, 8'h03, 3, 1);
        add(0, 0, 3, 3, 0, 8'h03, 3, 0);   // paused: hold
        add(0, 1, 3, 3, 0, 8'h07, 3, 1);
        add(0, 0, 3, 3, 0, 8'h07, 3, 0);
        add(0, 1, 3, 3, 0, 8'h0F, 3, 1);
        add(0, 1, 3, 3, 0, 8'h1F, 3, 1);
        add(0, 1, 3, 0, 1, 8'h01, 0, 0);   // load beats step
        add(0, 0, 3, 0, 0, 8'h01, 0, 0);
        add(1, 0, 3, 0, 0, 8'h02, 0, 1);

        rs = 1'b0; run = 1'b0; step = 1'b0; speed = 2'd0;
        mode_sel = 2'd0; mode_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset led", led, 8'h01);
        chk("reset mode", 8'(mode), 8'h00);
        chk("reset tick", 8'(tick), 8'h00);

        // Free-running rotate left, period 8.
        rs = 1'b1; run = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c < 8) begin
                    chk($sformatf("rotl s%0d c%0d tick", s, c), 8'(tick), 8'h00);
                end else begin
                    chk($sformatf("rotl s%0d led", s), led, rotl_seq[s]);
                    chk($sformatf("rotl s%0d tick", s), 8'(tick), 8'h01);
                end
            end
        end

        // Table vectors.
        foreach (vecs[i]) begin
            run = vecs[i].run; step = vecs[i].step; speed = vecs[i].speed;
            mode_sel = vecs[i].sel; mode_load = vecs[i].load;
            @(negedge clk);
            chk($sformatf("vec%0d led", i), led, vecs[i].exp_led);
            chk($sformatf("vec%0d mode", i), 8'(mode), 8'(vecs[i].exp_mode));
            chk($sformatf("vec%0d tick", i), 8'(tick), 8'(vecs[i].exp_tick));
        end
        step = 1'b0; mode_load = 1'b0;

        // Pause mid-count, single step, resume from the held count.
        run = 1'b1; speed = 2'd0; mode_sel = 2'd0; mode_load = 1'b1;
        @(negedge clk);
        mode_load = 1'b0;
        chk("pause load led", led, 8'h01);
        chk("pause load tick", 8'(tick), 8'h00);
        repeat (3) @(negedge clk);
        run = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("paused c%0d led", c), led, 8'h01);
            chk($sformatf("paused c%0d tick", c), 8'(tick), 8'h00);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step led", led, 8'h02);
        chk("step tick", 8'(tick), 8'h01);
        @(negedge clk);
        chk("step tick drop", 8'(tick), 8'h00);
        run = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step = (c == 2);
            @(negedge clk);
            if (c < 5) begin
                chk($sformatf("resume c%0d led", c), led, 8'h02);
                chk($sformatf("resume c%0d tick", c), 8'(tick), 8'h00);
            end else begin
                chk("resume led", led, 8'h04);
                chk("resume tick", 8'(tick), 8'h01);
            end
        end
        step = 1'b0;

        // Speed raised mid-count wraps on the next cycle.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("pre-speed c%0d tick", c), 8'(tick), 8'h00);
        end
        speed = 2'd2;
        @(negedge clk);
        chk("speedup led", led, 8'h08);
        chk("speedup tick", 8'(tick), 8'h01);
        @(negedge clk);
        chk("speed2 gap led", led, 8'h08);
        chk("speed2 gap tick", 8'(tick), 8'h00);
        @(negedge clk);
        chk("speed2 led", led, 8'h10);
        chk("speed2 tick", 8'(tick), 8'h01);

        // Asynchronous reset mid-operation, then restart timing.
        mode_sel = 2'd1; mode_load = 1'b1; speed = 2'd3;
        @(negedge clk);
        mode_load = 1'b0;
        chk("pre-rst mode", 8'(mode), 8'h01);
        @(negedge clk);
        chk("pre-rst led", led, 8'h80);
        chk("pre-rst tick", 8'(tick), 8'h01);
        #2 rs = 1'b0;
        #1;
        chk("async rst led", led, 8'h01);
        chk("async rst tick", 8'(tick), 8'h00);
        chk("async rst mode", 8'(mode), 8'h00);
        @(negedge clk);
        speed = 2'd0; run = 1'b1; rs = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c < 8) begin
                chk($sformatf("post-rst c%0d tick", c), 8'(tick), 8'h00);
            end else begin
                chk("post-rst led", led, 8'h02);
                chk("post-rst tick", 8'(tick), 8'h01);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
